bram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single PL-side BRAM port B (the port the ZYNQ_BRAM_wrapper exposes to fabric) between two masters, e.g. the matrix operand loader and the result writer of the 2x2 multiplier. It accepts single-beat read/write requests, issues them to the BRAM in grant order with round-robin fairness and optional bounded burst locking, and routes read data back to the issuing requester with a fixed, parameterised latency.

---
 rtl/bram_port_arbiter_if.sv | 25 ++
 rtl/bram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Single-beat request channel between one requester and the BRAM port arbiter.
// The requester holds req and its fields stable until gnt; read data returns on rvalid/rdata.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two single-beat requesters,
// with bounded burst locking and fixed-latency read data return tagged by requester.
module bram_port_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  bram_port_arbiter_if.slave rq0,
  bram_port_arbiter_if.slave rq1,
  output logic               BRAM_clk,
  output logic [ADDR_W-1:0]  BRAM_addr,
  output logic [DATA_W-1:0]  BRAM_din,
  input  logic [DATA_W-1:0]  BRAM_dout,
  output logic               BRAM_en,
  output logic               BRAM_we
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  logic              gnt0_s, gnt1_s, any_gnt_s;
  logic              sel_s, sel_we_s, sel_lock_s, other_req_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              en_r, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] din_r;
  logic [RD_LAT:0]   tag_vld_r, tag_id_r;
  logic              rvalid0_r, rvalid1_r;
  logic [DATA_W-1:0] rdata0_r, rdata1_r;

  // Grant decision: ptr only breaks ties; no grant is ever given while reset is held.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rstn) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (rq0.req && rq1.req) begin
      gnt0_s = ~ptr_r;
      gnt1_s = ptr_r;
    end else begin
      gnt0_s = rq0.req;
      gnt1_s = rq1.req;
    end
  end

  assign any_gnt_s   = gnt0_s | gnt1_s;
  assign sel_s       = gnt1_s;
  assign sel_we_s    = sel_s ? rq1.we    : rq0.we;
  assign sel_lock_s  = sel_s ? rq1.lock  : rq0.lock;
  assign other_req_s = sel_s ? rq0.req   : rq1.req;
  assign sel_addr_s  = sel_s ? rq1.addr  : rq0.addr;
  assign sel_wdata_s = sel_s ? rq1.wdata : rq0.wdata;

  // Fairness update: a locking owner keeps the port, but only MAX_BURST grants in a row while contended.
  always_comb begin
    ptr_nxt_s = ptr_r;
    cnt_nxt_s = cnt_r;
    if (!any_gnt_s) begin
      ptr_nxt_s = ptr_r;
      cnt_nxt_s = cnt_r;
    end else if (sel_lock_s && other_req_s && (cnt_r < BURST_LAST)) begin
      ptr_nxt_s = sel_s;
      cnt_nxt_s = cnt_r + CNT_W'(1'b1);
    end else if (sel_lock_s && !other_req_s) begin
      ptr_nxt_s = sel_s;
      cnt_nxt_s = cnt_r;
    end else begin
      ptr_nxt_s = ~sel_s;
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // BRAM issue stage: address and data hold when idle so the port does not toggle needlessly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_r   <= 1'b0;
      we_r   <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      din_r  <= {DATA_W{1'b0}};
    end else if (any_gnt_s) begin
      en_r   <= 1'b1;
      we_r   <= sel_we_s;
      addr_r <= sel_addr_s;
      din_r  <= sel_wdata_s;
    end else begin
      en_r   <= 1'b0;
      we_r   <= 1'b0;
    end
  end

  // Read tag pipe: stage 0 lines up with the issue cycle, stage RD_LAT with valid BRAM_dout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_r <= {(RD_LAT+1){1'b0}};
      tag_id_r  <= {(RD_LAT+1){1'b0}};
    end else begin
      tag_vld_r <= {tag_vld_r[RD_LAT-1:0], any_gnt_s & ~sel_we_s};
      tag_id_r  <= {tag_id_r[RD_LAT-1:0], sel_s};
    end
  end

  // Response return: only the tagged requester sees rvalid; the other side's rdata holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DATA_W{1'b0}};
      rdata1_r  <= {DATA_W{1'b0}};
    end else begin
      rvalid0_r <= tag_vld_r[RD_LAT] & ~tag_id_r[RD_LAT];
      rvalid1_r <= tag_vld_r[RD_LAT] &  tag_id_r[RD_LAT];
      if (tag_vld_r[RD_LAT] && !tag_id_r[RD_LAT]) begin
        rdata0_r <= BRAM_dout;
      end
      if (tag_vld_r[RD_LAT] && tag_id_r[RD_LAT]) begin
        rdata1_r <= BRAM_dout;
      end
    end
  end

  assign rq0.gnt    = gnt0_s;
  assign rq1.gnt    = gnt1_s;
  assign rq0.rvalid = rvalid0_r;
  assign rq1.rvalid = rvalid1_r;
  assign rq0.rdata  = rdata0_r;
  assign rq1.rdata  = rdata1_r;

  assign BRAM_clk  = clk;
  assign BRAM_en   = en_r;
  assign BRAM_we   = we_r;
  assign BRAM_addr = addr_r;
  assign BRAM_din  = din_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a grant/issue vector table plus hand-written
// sequences for read latency, write-then-read, mid-flight reset and an RD_LAT=3 instance.
module tb_bram_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  logic          m1_clk, m1_en, m1_we, m3_clk, m3_en, m3_we;
  logic [AW-1:0] m1_addr, m3_addr;
  logic [DW-1:0] m1_din, m1_dout, m3_din, m3_dout;

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(4)) u_dut1 (
    .clk(clk), .rstn(rstn), .rq0(a0.slave), .rq1(a1.slave),
    .BRAM_clk(m1_clk), .BRAM_addr(m1_addr), .BRAM_din(m1_din), .BRAM_dout(m1_dout),
    .BRAM_en(m1_en), .BRAM_we(m1_we)
  );

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_BURST(4)) u_dut3 (
    .clk(clk), .rstn(rstn), .rq0(b0.slave), .rq1(b1.slave),
    .BRAM_clk(m3_clk), .BRAM_addr(m3_addr), .BRAM_din(m3_din), .BRAM_dout(m3_dout),
    .BRAM_en(m3_en), .BRAM_we(m3_we)
  );

  // BRAM models (read-first), with a preload port driven by the bench
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem1 [0:8191];
  logic [DW-1:0] mem3 [0:8191];
  logic [DW-1:0] dq1;
  logic [DW-1:0] dq3 [1:3];

  always @(posedge clk) begin
    if (pre_en) mem1[pre_addr] <= pre_data;
    else if (m1_en && m1_we) mem1[m1_addr] <= m1_din;
    dq1 <= mem1[m1_addr];
  end
  assign m1_dout = dq1;

  always @(posedge clk) begin
    if (pre_en) mem3[pre_addr] <= pre_data;
    else if (m3_en && m3_we) mem3[m3_addr] <= m3_din;
    dq3[1] <= mem3[m3_addr];
    dq3[2] <= dq3[1];
    dq3[3] <= dq3[2];
  end
  assign m3_dout = dq3[3];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]    ctl;   // {req0, req1, lock0, lock1, we0, we1}
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    eg;    // {gnt0, gnt1}
    logic          een;
    logic          ewe;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t tbl [29];

  task automatic preload(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = ad; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt0"}, a0.gnt, 1'b0);
    chk({tag, "_gnt1"}, a1.gnt, 1'b0);
    chk({tag, "_en"}, m1_en, 1'b0);
    chk({tag, "_we"}, m1_we, 1'b0);
    chk({tag, "_addr"}, m1_addr, 32'h0);
    chk({tag, "_din"}, m1_din, 32'h0);
    chk({tag, "_rvalid0"}, a0.rvalid, 1'b0);
    chk({tag, "_rvalid1"}, a1.rvalid, 1'b0);
    chk({tag, "_rdata0"}, a0.rdata, 32'h0);
    chk({tag, "_rdata1"}, a1.rdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    a0.req = 1'b1; a1.req = 1'b1;
    #1;
    check_reset_outputs("rst");
    a0.req = 1'b0; a1.req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int seen;
    int j;
    logic [DW-1:0] exp_d;
    rstn = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    {a0.req, a0.we, a0.lock, a0.addr, a0.wdata} = '0;
    {a1.req, a1.we, a1.lock, a1.addr, a1.wdata} = '0;
    {b0.req, b0.we, b0.lock, b0.addr, b0.wdata} = '0;
    {b1.req, b1.we, b1.lock, b1.addr, b1.wdata} = '0;

    // Grant/issue table; starts from ptr=0, burst count 0
    tbl[0] = '{6'b000000, 13'h000, 13'h000, 2'b00, 1'b0, 1'b0, 13'h000};
    tbl[1] = '{6'b100000, 13'h010, 13'h000, 2'b10, 1'b1, 1'b0, 13'h010};
    tbl[2] = '{6'b010001, 13'h000, 13'h020, 2'b01, 1'b1, 1'b1, 13'h020};
    for (int k = 0; k < 6; k++)
      tbl[3+k] = (k % 2 == 0) ? '{6'b110000, 13'h100, 13'h200, 2'b10, 1'b1, 1'b0, 13'h100}
                              : '{6'b110000, 13'h100, 13'h200, 2'b01, 1'b1, 1'b0, 13'h200};
    tbl[9] = '{6'b000000, 13'h100, 13'h200, 2'b00, 1'b0, 1'b0, 13'h200};
    for (int k = 0; k < 10; k++)
      tbl[10+k] = (k == 4 || k == 9) ? '{6'b111000, 13'h111, 13'h222, 2'b01, 1'b1, 1'b0, 13'h222}
                                     : '{6'b111000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[20] = '{6'b101000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[21] = '{6'b110000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[22] = '{6'b110000, 13'h111, 13'h222, 2'b01, 1'b1, 1'b0, 13'h222};
    tbl[23] = '{6'b111000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[24] = '{6'b111000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[25] = '{6'b101000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[26] = '{6'b111000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[27] = '{6'b111000, 13'h111, 13'h222, 2'b10, 1'b1, 1'b0, 13'h111};
    tbl[28] = '{6'b111000, 13'h111, 13'h222, 2'b01, 1'b1, 1'b0, 13'h222};

    preload(13'h010, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) preload(13'h040 + 13'(i), 32'hC0DE0000 + 32'(i * 32'h111));

    // Reset, then a single read from requester 0 (RD_LAT=1)
    do_reset();
    @(negedge clk);
    chk("bram_clk", {31'h0, m1_clk}, {31'h0, clk});
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 13'h010; a0.lock = 1'b0;
    #1;
    chk("rd_gnt0", a0.gnt, 1'b1);
    chk("rd_gnt1", a1.gnt, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) a0.req = 1'b0;
      #1;
      if (k == 1) begin
        chk("rd_en", m1_en, 1'b1);
        chk("rd_we", m1_we, 1'b0);
        chk("rd_addr", m1_addr, 32'h010);
      end
      chk($sformatf("rd_rvalid0_k%0d", k), a0.rvalid, (k == 3) ? 1'b1 : 1'b0);
      chk($sformatf("rd_rvalid1_k%0d", k), a1.rvalid, 1'b0);
      if (k == 3) chk("rd_rdata0", a0.rdata, 32'hDEADBEEF);
    end

    // Table: contention, locking bursts, idle cycles
    do_reset();
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      {a0.req, a1.req, a0.lock, a1.lock, a0.we, a1.we} = tbl[i].ctl;
      a0.addr = tbl[i].a0; a1.addr = tbl[i].a1;
      a0.wdata = {19'h0, tbl[i].a0}; a1.wdata = {19'h0, tbl[i].a1};
      #1;
      chk($sformatf("tbl%0d_gnt0", i), a0.gnt, tbl[i].eg[1]);
      chk($sformatf("tbl%0d_gnt1", i), a1.gnt, tbl[i].eg[0]);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_en", i), m1_en, tbl[i].een);
      chk($sformatf("tbl%0d_we", i), m1_we, tbl[i].ewe);
      chk($sformatf("tbl%0d_addr", i), m1_addr, tbl[i].eaddr);
    end
    @(negedge clk);
    {a0.req, a1.req, a0.lock, a1.lock, a0.we, a1.we} = 6'b000000;

    // Write then read on requester 1 at the top address
    @(negedge clk);
    a1.req = 1'b1; a1.we = 1'b1; a1.addr = 13'h1FFF; a1.wdata = 32'h12345678; a1.lock = 1'b0;
    #1;
    chk("wr_gnt1", a1.gnt, 1'b1);
    @(negedge clk);
    a1.we = 1'b0;
    #1;
    chk("wr_en", m1_en, 1'b1);
    chk("wr_we", m1_we, 1'b1);
    chk("wr_addr", m1_addr, 32'h1FFF);
    chk("wr_din", m1_din, 32'h12345678);
    chk("wr_rd_gnt1", a1.gnt, 1'b1);
    seen = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a1.req = 1'b0;
      #1;
      if (k == 1) chk("wr_rd_we", m1_we, 1'b0);
      if (a1.rvalid && seen < 0) begin
        seen = k;
        chk("wr_rd_rdata1", a1.rdata, 32'h12345678);
      end
      chk($sformatf("wr_rvalid0_k%0d", k), a0.rvalid, 1'b0);
    end
    chk("wr_rd_latency", 32'(seen), 32'd3);

    // Reset while a read is in flight
    @(negedge clk);
    a0.req = 1'b1; a0.we = 1'b0; a0.addr = 13'h010;
    #1;
    chk("mid_gnt0", a0.gnt, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    a1.req = 1'b1;
    #1;
    check_reset_outputs("mid");
    a0.req = 1'b0; a1.req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_norv0_k%0d", k), a0.rvalid, 1'b0);
      chk($sformatf("mid_norv1_k%0d", k), a1.rvalid, 1'b0);
    end
    @(negedge clk);
    a0.req = 1'b1; a1.req = 1'b1;
    #1;
    chk("mid_after_gnt0", a0.gnt, 1'b1);
    chk("mid_after_gnt1", a1.gnt, 1'b0);
    @(negedge clk);
    a0.req = 1'b0; a1.req = 1'b0;

    // RD_LAT=3 instance: 8 back-to-back reads alternating requesters, rvalid 5 cycles after gnt
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        b0.req = (cyc % 2 == 0); b1.req = (cyc % 2 == 1);
        b0.addr = 13'h040 + 13'(cyc); b1.addr = 13'h040 + 13'(cyc);
      end else begin
        b0.req = 1'b0; b1.req = 1'b0;
      end
      #1;
      if (cyc < 8) begin
        chk($sformatf("l3_gnt0_c%0d", cyc), b0.gnt, (cyc % 2 == 0) ? 1'b1 : 1'b0);
        chk($sformatf("l3_gnt1_c%0d", cyc), b1.gnt, (cyc % 2 == 1) ? 1'b1 : 1'b0);
      end
      j = cyc - 5;
      exp_d = 32'hC0DE0000 + 32'(j * 32'h111);
      chk($sformatf("l3_rv0_c%0d", cyc), b0.rvalid, (j >= 0 && j < 8 && j % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("l3_rv1_c%0d", cyc), b1.rvalid, (j >= 0 && j < 8 && j % 2 == 1) ? 1'b1 : 1'b0);
      if (j >= 0 && j < 8 && j % 2 == 0) chk($sformatf("l3_rd0_c%0d", cyc), b0.rdata, exp_d);
      if (j >= 0 && j < 8 && j % 2 == 1) chk($sformatf("l3_rd1_c%0d", cyc), b1.rdata, exp_d);
    end
    chk("bram_clk3", {31'h0, m3_clk}, {31'h0, clk});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
